// File: rtl/ma_redirect_ctrl_pkg.sv
// Shared types for the MA-stage redirect controller: FSM states and redirect causes.
package ma_redirect_ctrl_pkg;

    typedef enum logic [1:0] {
        RS_BOOT  = 2'd0,
        RS_IDLE  = 2'd1,
        RS_REDIR = 2'd2
    } redir_state;

    typedef enum logic [1:0] {
        RC_EXC  = 2'd0,
        RC_INT  = 2'd1,
        RC_MRET = 2'd2,
        RC_RST  = 2'd3
    } redir_cause;

    localparam int ADDR_W = 32;

endpackage

// File: rtl/redir_arbiter.sv
// Fixed-priority selection of the MA redirect source, with escalation of runaway restart loops
// into an exception redirect.
module redir_arbiter
    import ma_redirect_ctrl_pkg::*;
#(
    parameter int MAX_RST = 7,
    parameter int CNT_W   = 3
) (
    input  logic              s_sample_i,
    input  logic              s_exception_i,
    input  logic [31:0]       s_exc_trap_i,
    input  logic              s_int_pending_i,
    input  logic [31:0]       s_int_trap_i,
    input  logic              s_treturn_i,
    input  logic [31:0]       s_mepc_i,
    input  logic              s_rstpp_i,
    input  logic [31:0]       s_rst_point_i,
    input  logic [CNT_W-1:0]  s_rstcnt_i,
    output logic              s_event_o,
    output redir_cause        s_cause_o,
    output logic [31:0]       s_target_o,
    output logic              s_escalate_o
);

    always_comb begin
        s_event_o    = 1'b0;
        s_cause_o    = RC_EXC;
        s_target_o   = s_exc_trap_i;
        s_escalate_o = 1'b0;
        if (s_sample_i) begin
            if (s_exception_i) begin
                s_event_o = 1'b1;
            end else if (s_int_pending_i) begin
                s_event_o  = 1'b1;
                s_cause_o  = RC_INT;
                s_target_o = s_int_trap_i;
            end else if (s_treturn_i) begin
                s_event_o  = 1'b1;
                s_cause_o  = RC_MRET;
                s_target_o = s_mepc_i;
            end else if (s_rstpp_i) begin
                s_event_o = 1'b1;
                // A restart with the counter already at its limit becomes a trap instead.
                if (s_rstcnt_i == CNT_W'(MAX_RST)) begin
                    s_escalate_o = 1'b1;
                end else begin
                    s_cause_o  = RC_RST;
                    s_target_o = s_rst_point_i;
                end
            end
        end
    end

endmodule

// File: rtl/seu_regs.sv
// Plain register bank with asynchronous active-low clear to zero; the instance name labels
// the bank so fault injection can target it.
module seu_regs #(
    parameter int W = 1
) (
    input  logic         s_clk_i,
    input  logic         s_resetn_i,
    input  logic [W-1:0] s_d_i,
    output logic [W-1:0] s_q_o
);

    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            s_q_o <= '0;
        end else begin
            s_q_o <= s_d_i;
        end
    end

endmodule

// File: rtl/ma_redirect_ctrl.sv
// MA-stage redirect controller: turns CSR-unit events into one fetch redirect, sequences the
// front-end flush and escalates runaway pipeline-restart loops.
module ma_redirect_ctrl
    import ma_redirect_ctrl_pkg::*;
#(
    parameter int MAX_RST = 7,
    parameter int CNT_W   = 3
) (
    input  logic              s_clk_i,
    input  logic              s_resetn_i,
    input  logic [31:0]       s_boot_add_i,
    input  logic              s_stall_i,
    input  logic              s_valid_i,
    input  logic              s_exception_i,
    input  logic [31:0]       s_exc_trap_i,
    input  logic              s_int_pending_i,
    input  logic [31:0]       s_int_trap_i,
    input  logic              s_treturn_i,
    input  logic [31:0]       s_mepc_i,
    input  logic              s_rstpp_i,
    input  logic [31:0]       s_rst_point_i,
    input  logic              s_fe_ready_i,
    output logic              s_redirect_o,
    output logic [31:0]       s_redirect_add_o,
    output logic              s_flush_o,
    output logic              s_interrupted_o,
    output logic              s_rstmax_o,
    output logic [CNT_W-1:0]  s_rstcnt_o,
    output logic [1:0]        s_dbg_state_o
);

    // Handshake: s_redirect_o/s_redirect_add_o act as valid/data and stay stable until a cycle
    // with s_fe_ready_i high; the transfer completes on that clock edge.
    logic [1:0]       state_q, state_d;
    logic [31:0]      target_q, target_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       pulse_q, pulse_d;
    redir_state       state, state_n;

    logic             sample;
    logic             arb_event;
    redir_cause       arb_cause;
    logic [31:0]      arb_target;
    logic             arb_escalate;

    seu_regs #(.W(2)) REDIR_STATE (
        .s_clk_i(s_clk_i), .s_resetn_i(s_resetn_i), .s_d_i(state_d), .s_q_o(state_q)
    );

    seu_regs #(.W(32)) REDIR_TARGET (
        .s_clk_i(s_clk_i), .s_resetn_i(s_resetn_i), .s_d_i(target_d), .s_q_o(target_q)
    );

    seu_regs #(.W(CNT_W)) REDIR_RSTCNT (
        .s_clk_i(s_clk_i), .s_resetn_i(s_resetn_i), .s_d_i(cnt_d), .s_q_o(cnt_q)
    );

    seu_regs #(.W(2)) REDIR_PULSE (
        .s_clk_i(s_clk_i), .s_resetn_i(s_resetn_i), .s_d_i(pulse_d), .s_q_o(pulse_q)
    );

    assign state  = redir_state'(state_q);
    assign sample = (state == RS_IDLE) & s_valid_i & ~s_stall_i;

    redir_arbiter #(.MAX_RST(MAX_RST), .CNT_W(CNT_W)) u_arbiter (
        .s_sample_i      (sample),
        .s_exception_i   (s_exception_i),
        .s_exc_trap_i    (s_exc_trap_i),
        .s_int_pending_i (s_int_pending_i),
        .s_int_trap_i    (s_int_trap_i),
        .s_treturn_i     (s_treturn_i),
        .s_mepc_i        (s_mepc_i),
        .s_rstpp_i       (s_rstpp_i),
        .s_rst_point_i   (s_rst_point_i),
        .s_rstcnt_i      (cnt_q),
        .s_event_o       (arb_event),
        .s_cause_o       (arb_cause),
        .s_target_o      (arb_target),
        .s_escalate_o    (arb_escalate)
    );

    always_comb begin
        state_n = state;
        case (state)
            RS_BOOT:  if (s_fe_ready_i) state_n = RS_IDLE;
            RS_IDLE:  if (arb_event)    state_n = RS_REDIR;
            RS_REDIR: if (s_fe_ready_i) state_n = RS_IDLE;
            default:  state_n = RS_BOOT;
        endcase
    end

    always_comb begin
        state_d  = state_n;
        target_d = arb_event ? arb_target : target_q;
        pulse_d  = {arb_event & (arb_cause == RC_INT), arb_escalate};
        cnt_d    = cnt_q;
        if (arb_event) begin
            if (arb_escalate) begin
                cnt_d = '0;
            end else if (arb_cause == RC_RST && cnt_q < CNT_W'(MAX_RST)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (sample) begin
            // A clean retirement breaks the restart loop.
            cnt_d = '0;
        end
    end

    assign s_redirect_o     = (state != RS_IDLE);
    assign s_flush_o        = (state != RS_IDLE);
    assign s_redirect_add_o = (state == RS_BOOT) ? s_boot_add_i : target_q;
    assign s_interrupted_o  = pulse_q[1];
    assign s_rstmax_o       = pulse_q[0];
    assign s_rstcnt_o       = cnt_q;
    assign s_dbg_state_o    = state_q;

endmodule

// File: tb/tb_ma_redirect_ctrl.sv
// Directed scoreboard bench for ma_redirect_ctrl (MAX_RST=3): boot handshake, priority,
// interrupt pulse, restart escalation, stall gating, REDIR masking and async reset.
module tb_ma_redirect_ctrl;

    localparam int VW = 41;
    localparam logic [1:0] ST_B = 2'd0;
    localparam logic [1:0] ST_I = 2'd1;
    localparam logic [1:0] ST_R = 2'd2;

    logic        clk;
    logic        rst_n;
    logic [31:0] boot_add;
    logic        stall, valid, exception, int_pending, treturn, rstpp, fe_ready;
    logic [31:0] exc_trap, int_trap, mepc, rst_point;
    logic        redirect, flush, interrupted, rstmax;
    logic [31:0] redirect_add;
    logic [2:0]  rstcnt;
    logic [1:0]  dbg_state;
    logic [VW-1:0] obs;

    logic [VW-1:0] exp_q[$];
    int n_vec;
    int n_err;

    ma_redirect_ctrl #(.MAX_RST(3), .CNT_W(3)) dut (
        .s_clk_i          (clk),
        .s_resetn_i       (rst_n),
        .s_boot_add_i     (boot_add),
        .s_stall_i        (stall),
        .s_valid_i        (valid),
        .s_exception_i    (exception),
        .s_exc_trap_i     (exc_trap),
        .s_int_pending_i  (int_pending),
        .s_int_trap_i     (int_trap),
        .s_treturn_i      (treturn),
        .s_mepc_i         (mepc),
        .s_rstpp_i        (rstpp),
        .s_rst_point_i    (rst_point),
        .s_fe_ready_i     (fe_ready),
        .s_redirect_o     (redirect),
        .s_redirect_add_o (redirect_add),
        .s_flush_o        (flush),
        .s_interrupted_o  (interrupted),
        .s_rstmax_o       (rstmax),
        .s_rstcnt_o       (rstcnt),
        .s_dbg_state_o    (dbg_state)
    );

    assign obs = {dbg_state, redirect, flush, redirect_add, interrupted, rstmax, rstcnt};

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [VW-1:0] vec(logic [1:0] st, logic r, logic f, logic [31:0] a,
                                          logic i, logic m, logic [2:0] c);
        return {st, r, f, a, i, m, c};
    endfunction

    task automatic check_vec(string tag, logic [VW-1:0] got, logic [VW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got st=%0d rd=%b fl=%b add=%h int=%b max=%b cnt=%0d, want st=%0d rd=%b fl=%b add=%h int=%b max=%b cnt=%0d",
                     tag, got[40:39], got[38], got[37], got[36:5], got[4], got[3], got[2:0],
                     exp[40:39], exp[38], exp[37], exp[36:5], exp[4], exp[3], exp[2:0]);
        end
    endtask

    // Driver tasks
    task automatic expect_v(logic [VW-1:0] e);
        exp_q.push_back(e);
    endtask

    task automatic sample(string tag);
        logic [VW-1:0] e;
        if (exp_q.size() == 0) e = 'x;
        else e = exp_q.pop_front();
        check_vec(tag, obs, e);
    endtask

    task automatic tick(string tag);
        @(posedge clk);
        #1;
        sample(tag);
    endtask

    task automatic clr_ev();
        valid = 0; stall = 0; exception = 0; int_pending = 0; treturn = 0; rstpp = 0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 0;
        fe_ready = 0;
        boot_add = 32'h0000_0100;
        exc_trap = 32'h200;
        int_trap = 32'h300;
        mepc = 32'h500;
        rst_point = 32'h400;
        clr_ev();

        #3;
        expect_v(vec(ST_B, 1, 1, 32'h100, 0, 0, 0));
        sample("reset");

        // Boot: ready low for 3 edges, redirect visible for 4 cycles
        @(negedge clk);
        rst_n = 1;
        #1;
        expect_v(vec(ST_B, 1, 1, 32'h100, 0, 0, 0));
        sample("boot_c1");
        for (int k = 0; k < 3; k++) begin
            expect_v(vec(ST_B, 1, 1, 32'h100, 0, 0, 0));
            tick("boot_wait");
        end
        fe_ready = 1;
        expect_v(vec(ST_I, 0, 0, 32'h0, 0, 0, 0));
        tick("boot_exit");
        fe_ready = 0;
        expect_v(vec(ST_I, 0, 0, 32'h0, 0, 0, 0));
        tick("idle_quiet");

        // Exception beats interrupt
        valid = 1; exception = 1; int_pending = 1;
        expect_v(vec(ST_R, 1, 1, 32'h200, 0, 0, 0));
        tick("exc_over_int");
        clr_ev(); fe_ready = 1;
        expect_v(vec(ST_I, 0, 0, 32'h200, 0, 0, 0));
        tick("exc_done");
        fe_ready = 0;

        // Interrupt alone: one-cycle approval pulse while REDIR waits
        valid = 1; int_pending = 1;
        expect_v(vec(ST_R, 1, 1, 32'h300, 1, 0, 0));
        tick("int_taken");
        clr_ev();
        expect_v(vec(ST_R, 1, 1, 32'h300, 0, 0, 0));
        tick("int_pulse_end");
        fe_ready = 1;
        expect_v(vec(ST_I, 0, 0, 32'h300, 0, 0, 0));
        tick("int_done");
        fe_ready = 0;

        // Back-to-back restarts without retirement, then escalation
        for (int k = 1; k <= 3; k++) begin
            valid = 1; rstpp = 1;
            expect_v(vec(ST_R, 1, 1, 32'h400, 0, 0, 3'(k)));
            tick("rst_redir");
            clr_ev(); fe_ready = 1;
            expect_v(vec(ST_I, 0, 0, 32'h400, 0, 0, 3'(k)));
            tick("rst_done");
            fe_ready = 0;
        end
        valid = 1; rstpp = 1;
        expect_v(vec(ST_R, 1, 1, 32'h200, 0, 1, 0));
        tick("rst_escalate");
        expect_v(vec(ST_R, 1, 1, 32'h200, 0, 0, 0));
        tick("rst_ignored_in_redir");
        clr_ev(); fe_ready = 1;
        expect_v(vec(ST_I, 0, 0, 32'h200, 0, 0, 0));
        tick("escalate_done");
        fe_ready = 0;

        // Retirement clears the counter; exception/interrupt with rstpp leave it alone
        valid = 1; rstpp = 1;
        expect_v(vec(ST_R, 1, 1, 32'h400, 0, 0, 1));
        tick("rst_one");
        clr_ev(); fe_ready = 1;
        expect_v(vec(ST_I, 0, 0, 32'h400, 0, 0, 1));
        tick("rst_one_done");
        fe_ready = 0; valid = 1;
        expect_v(vec(ST_I, 0, 0, 32'h400, 0, 0, 0));
        tick("retire_clear");
        rstpp = 1;
        expect_v(vec(ST_R, 1, 1, 32'h400, 0, 0, 1));
        tick("rst_after_clear");
        clr_ev(); fe_ready = 1;
        expect_v(vec(ST_I, 0, 0, 32'h400, 0, 0, 1));
        tick("rst_after_clear_done");
        fe_ready = 0;
        valid = 1; rstpp = 1; exception = 1;
        expect_v(vec(ST_R, 1, 1, 32'h200, 0, 0, 1));
        tick("exc_over_rst");
        clr_ev(); fe_ready = 1;
        expect_v(vec(ST_I, 0, 0, 32'h200, 0, 0, 1));
        tick("exc_over_rst_done");
        fe_ready = 0;
        valid = 1; rstpp = 1; int_pending = 1;
        expect_v(vec(ST_R, 1, 1, 32'h300, 1, 0, 1));
        tick("int_over_rst");
        clr_ev(); fe_ready = 1;
        expect_v(vec(ST_I, 0, 0, 32'h300, 0, 0, 1));
        tick("int_over_rst_done");
        fe_ready = 0;
        valid = 1; stall = 1;
        expect_v(vec(ST_I, 0, 0, 32'h300, 0, 0, 1));
        tick("stall_no_clear");
        stall = 0;
        expect_v(vec(ST_I, 0, 0, 32'h300, 0, 0, 0));
        tick("retire_clear2");

        // MRET held off by stall, then taken; exception in REDIR ignored
        valid = 1; treturn = 1; stall = 1;
        for (int k = 0; k < 2; k++) begin
            expect_v(vec(ST_I, 0, 0, 32'h300, 0, 0, 0));
            tick("mret_stalled");
        end
        stall = 0;
        expect_v(vec(ST_R, 1, 1, 32'h500, 0, 0, 0));
        tick("mret_taken");
        clr_ev(); valid = 1; exception = 1;
        expect_v(vec(ST_R, 1, 1, 32'h500, 0, 0, 0));
        tick("exc_in_redir");
        clr_ev(); fe_ready = 1;
        expect_v(vec(ST_I, 0, 0, 32'h500, 0, 0, 0));
        tick("mret_done");
        fe_ready = 0;

        // Async reset while REDIR waits for ready
        valid = 1; rstpp = 1;
        expect_v(vec(ST_R, 1, 1, 32'h400, 0, 0, 1));
        tick("rst_before_reset");
        clr_ev();
        expect_v(vec(ST_R, 1, 1, 32'h400, 0, 0, 1));
        tick("redir_waiting");
        #2;
        boot_add = 32'h180;
        rst_n = 0;
        #1;
        expect_v(vec(ST_B, 1, 1, 32'h180, 0, 0, 0));
        sample("async_reset");
        boot_add = 32'h1C0;
        #1;
        expect_v(vec(ST_B, 1, 1, 32'h1C0, 0, 0, 0));
        sample("boot_follow");
        @(negedge clk);
        rst_n = 1;
        fe_ready = 1;
        expect_v(vec(ST_I, 0, 0, 32'h0, 0, 0, 0));
        tick("reboot_exit");
        fe_ready = 0;

        // Final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
